// File: rtl/alu_defines.sv
// Shared ALU definitions: opcode encoding and pipeline depth
// for the pipelined ALU and the units that share it.
package alu_defines;

  localparam int ALU_LATENCY = 2;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared-ALU arbiter: issue handshake,
// kill controls and the tagged response bus.
interface alu_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  import alu_defines::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
  alu_op_t [NUM_REQ-1:0]              req_op;
  logic                               flush;
  logic [NUM_REQ-1:0]                 cancel;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_y;
  logic                               busy;
  logic                               err;

  modport master (
    output req_valid, req_a, req_b, req_op,
    output flush, cancel,
    input  req_ready, rsp_valid, rsp_y,
    input  busy, err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  flush, cancel,
    output req_ready, rsp_valid, rsp_y,
    output busy, err
  );

endinterface

// File: rtl/alu_pipelined.sv
// Two-stage ALU: operands registered, then result registered.
// Fixed latency, no stall; flush drops both valid bits.
module alu_pipelined
  import alu_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  valid_in,
  input  alu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] y
);

  logic                  v1_q, v2_q;
  alu_op_t               op1_q;
  logic [DATA_WIDTH-1:0] a1_q, b1_q, y2_q;
  logic [DATA_WIDTH-1:0] res;
  logic [4:0]            shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      op1_q <= ALU_ADD;
      a1_q  <= '0;
      b1_q  <= '0;
      v2_q  <= 1'b0;
      y2_q  <= '0;
    end else begin
      v1_q  <= valid_in & ~flush;
      op1_q <= op;
      a1_q  <= a;
      b1_q  <= b;
      v2_q  <= v1_q & ~flush;
      y2_q  <= res;
    end
  end

  assign shamt = b1_q[4:0];

  always_comb begin
    res = '0;
    unique case (op1_q)
      ALU_ADD:  res = a1_q + b1_q;
      ALU_SUB:  res = a1_q - b1_q;
      ALU_AND:  res = a1_q & b1_q;
      ALU_OR:   res = a1_q | b1_q;
      ALU_XOR:  res = a1_q ^ b1_q;
      ALU_SLL:  res = a1_q << shamt;
      ALU_SRL:  res = a1_q >> shamt;
      ALU_SRA:  res = $signed(a1_q) >>> shamt;
      ALU_SLT:  res[0] = $signed(a1_q) < $signed(b1_q);
      ALU_SLTU: res[0] = a1_q < b1_q;
      default:  res = '0;
    endcase
  end

  assign valid_out = v2_q;
  assign y         = y2_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or
// after the pointer, wrapping; one-hot grant plus its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          gnt_valid_o
);

  always_comb begin
    int idx;
    idx         = 0;
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_id_o    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters; a tag pipeline
// tracks owner and kill state of every op in flight.
module alu_arbiter
  import alu_defines::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = ALU_LATENCY
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic           valid;
    logic           kill;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t [LATENCY-1:0]    tag_q, tag_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    elig, gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  gnt_valid;

  logic                  alu_vout;
  logic [DATA_WIDTH-1:0] alu_y;

  tag_t                  fin;
  logic                  live;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_y;
  logic                  busy;

  function automatic logic hit(
    tag_t               t,
    logic               fl,
    logic [NUM_REQ-1:0] cn
  );
    return t.valid & (fl | cn[t.id]);
  endfunction

  assign elig = bus.req_valid & ~bus.cancel
              & {NUM_REQ{~(bus.flush | rst)}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr (
    .req_i       (elig),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  alu_pipelined #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .clk       (clk),
    .rst_n     (~rst),
    .flush     (1'b0),
    .valid_in  (gnt_valid),
    .op        (bus.req_op[gnt_id]),
    .a         (bus.req_a[gnt_id]),
    .b         (bus.req_b[gnt_id]),
    .valid_out (alu_vout),
    .y         (alu_y)
  );

  always_comb begin
    tag_d    = '0;
    ptr_d    = ptr_q;
    if (gnt_valid) begin
      tag_d[0].valid = 1'b1;
      tag_d[0].id    = gnt_id;
      ptr_d = (gnt_id == IDW'(NUM_REQ - 1))
            ? '0 : gnt_id + 1'b1;
    end
    // Kill marks ride along with the op as it shifts.
    for (int k = 1; k < LATENCY; k++) begin
      tag_d[k]      = tag_q[k-1];
      tag_d[k].kill = tag_q[k-1].kill
                    | hit(tag_q[k-1], bus.flush, bus.cancel);
    end
    err_d = err_q | (alu_vout != tag_q[LATENCY-1].valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign fin  = tag_q[LATENCY-1];
  assign live = fin.valid & ~fin.kill & ~rst
              & ~hit(fin, bus.flush, bus.cancel);

  always_comb begin
    rsp_valid = '0;
    rsp_y     = '0;
    busy      = 1'b0;
    if (live) begin
      rsp_valid[fin.id] = 1'b1;
      rsp_y             = alu_y;
    end
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.busy      = busy;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant order, latency, flush,
// cancel, reset mid-flight and pointer wrap.
module tb_alu_arbiter;
  import alu_defines::*;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

  alu_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .LATENCY    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.flush     = 1'b0;
    bus.cancel    = '0;
  endtask

  task automatic set_req(input int i, input alu_op_t op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_op[i]    = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  logic [31:0] exp_y [4];

  initial begin
    rst = 1'b1;
    idle();
    bus.req_a  = '0;
    bus.req_b  = '0;
    bus.req_op = {4{ALU_ADD}};
    step();
    step();

    // reset state, nothing granted while rst is high
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_rsp",   bus.rsp_valid, 4'b0000);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_err",   bus.err, 1'b0);
    chk("rst_y",     bus.rsp_y, 32'd0);

    // single requester: ADD(16,5) from req 1
    step();
    rst = 1'b0;
    idle();
    set_req(1, ALU_ADD, 32'd16, 32'd5);
    #1;
    chk("s_ready", bus.req_ready, 4'b0010);
    chk("s_busy0", bus.busy, 1'b0);
    step();
    idle();
    #1;
    chk("s_busy1", bus.busy, 1'b1);
    chk("s_rsp1",  bus.rsp_valid, 4'b0000);
    step();
    #1;
    chk("s_rsp2",  bus.rsp_valid, 4'b0010);
    chk("s_y",     bus.rsp_y, 32'd21);
    chk("s_busy2", bus.busy, 1'b1);
    step();
    #1;
    chk("s_busy3", bus.busy, 1'b0);
    chk("s_rsp3",  bus.rsp_valid, 4'b0000);

    // pointer wrap: pointer is 2, req 3 then req 0
    step();
    set_req(3, ALU_ADD, 32'd7, 32'd8);
    set_req(0, ALU_SUB, 32'd5, 32'd7);
    #1;
    chk("w_ready3", bus.req_ready, 4'b1000);
    step();
    bus.req_valid[3] = 1'b0;
    #1;
    chk("w_ready0", bus.req_ready, 4'b0001);
    step();
    idle();
    #1;
    chk("w_rsp3", bus.rsp_valid, 4'b1000);
    chk("w_y3",   bus.rsp_y, 32'd15);
    step();
    #1;
    chk("w_rsp0", bus.rsp_valid, 4'b0001);
    chk("w_y0",   bus.rsp_y, 32'hFFFF_FFFE);

    // flush kills two in-flight ops; pointer is 1
    step();
    set_req(0, ALU_SUB, 32'd200, 32'd10);
    set_req(2, ALU_XOR, 32'd300, 32'd30);
    #1;
    chk("f_ready2", bus.req_ready, 4'b0100);
    step();
    bus.req_valid[2] = 1'b0;
    #1;
    chk("f_ready0", bus.req_ready, 4'b0001);
    step();
    idle();
    bus.flush = 1'b1;
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    #1;
    chk("f_ready_fl", bus.req_ready, 4'b0000);
    chk("f_rsp_fl",   bus.rsp_valid, 4'b0000);
    step();
    bus.flush = 1'b0;
    #1;
    chk("f_ready1", bus.req_ready, 4'b0010);
    chk("f_rsp_k",  bus.rsp_valid, 4'b0000);
    step();
    idle();
    #1;
    chk("f_rsp_n", bus.rsp_valid, 4'b0000);
    chk("f_busy",  bus.busy, 1'b1);
    step();
    #1;
    chk("f_rsp1", bus.rsp_valid, 4'b0010);
    chk("f_y1",   bus.rsp_y, 32'd2);
    chk("f_err",  bus.err, 1'b0);

    // cancel[2] with req 2 and req 3 in flight; pointer is 2
    step();
    set_req(2, ALU_AND, 32'hFF, 32'h0F);
    set_req(3, ALU_OR, 32'd1, 32'd2);
    #1;
    chk("c_ready2", bus.req_ready, 4'b0100);
    step();
    bus.req_valid[2] = 1'b0;
    #1;
    chk("c_ready3", bus.req_ready, 4'b1000);
    step();
    bus.req_valid[2] = 1'b1;
    set_req(3, ALU_SUB, 32'd9, 32'd4);
    bus.cancel = 4'b0100;
    #1;
    chk("c_skip2", bus.req_ready, 4'b1000);
    chk("c_rsp2",  bus.rsp_valid, 4'b0000);
    step();
    idle();
    #1;
    chk("c_rsp3a", bus.rsp_valid, 4'b1000);
    chk("c_y3a",   bus.rsp_y, 32'd3);
    step();
    bus.cancel = 4'b0010;
    #1;
    chk("c_rsp3b", bus.rsp_valid, 4'b1000);
    chk("c_y3b",   bus.rsp_y, 32'd5);
    step();
    bus.cancel = '0;
    #1;
    chk("c_rsp_e", bus.rsp_valid, 4'b0000);
    chk("c_busy",  bus.busy, 1'b0);

    // reset one cycle after an accept; pointer is 0
    step();
    set_req(0, ALU_ADD, 32'd999, 32'd111);
    #1;
    chk("r_ready0", bus.req_ready, 4'b0001);
    step();
    rst = 1'b1;
    idle();
    bus.req_valid = 4'b0011;
    #1;
    chk("r_ready_rst", bus.req_ready, 4'b0000);
    chk("r_rsp_rst",   bus.rsp_valid, 4'b0000);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("r_rsp_a",  bus.rsp_valid, 4'b0000);
    chk("r_busy_a", bus.busy, 1'b0);
    step();
    #1;
    chk("r_rsp_b",  bus.rsp_valid, 4'b0000);
    chk("r_busy_b", bus.busy, 1'b0);

    // all four valid for 8 cycles; pointer restarts at 0
    exp_y[0] = 32'd13;
    exp_y[1] = 32'd7;
    exp_y[2] = 32'h30;
    exp_y[3] = 32'hC000_0000;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 8) begin
        set_req(0, ALU_ADD, 32'd10, 32'd3);
        set_req(1, ALU_SUB, 32'd10, 32'd3);
        set_req(2, ALU_AND, 32'hF0, 32'h3C);
        set_req(3, ALU_SRA, 32'h8000_0000, 32'd33);
      end else begin
        idle();
      end
      #1;
      if (i < 8)
        chk($sformatf("ord_ready%0d", i), bus.req_ready,
            64'(4'b0001 << (i % 4)));
      if (i >= 2) begin
        chk($sformatf("ord_rsp%0d", i), bus.rsp_valid,
            64'(4'b0001 << ((i - 2) % 4)));
        chk($sformatf("ord_y%0d", i), bus.rsp_y,
            64'(exp_y[(i - 2) % 4]));
      end
    end
    step();
    #1;
    chk("end_busy", bus.busy, 1'b0);
    chk("end_rsp",  bus.rsp_valid, 4'b0000);
    chk("end_err",  bus.err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu_pipelined instance (2-stage, fixed latency, no stall) between NUM_REQ requesters.
- Grants round-robin, issues at most one op per cycle, and carries a requester tag alongside the ALU pipeline.
- Routes each result back to its originating requester.
- Supports global flush and per-requester cancel of in-flight ops. Sits between the issue front-ends and the ALU.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: operand/result width, passed to alu_pipelined.
- LATENCY, 2: ALU latency in cycles. Must equal the alu_pipelined pipeline depth and the tag pipeline depth.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester op valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ x DATA_WIDTH  operand A per requester
- req_b  in  NUM_REQ x DATA_WIDTH  operand B per requester
- req_op  in  NUM_REQ x alu_op_t  opcode per requester
- flush  in  1  kill all in-flight ops, accept nothing this cycle
- cancel  in  NUM_REQ  kill in-flight ops of requester i, block its accept this cycle
- rsp_valid  out  NUM_REQ  one-hot result strobe
- rsp_y  out  DATA_WIDTH  shared result bus, valid where rsp_valid != 0
- busy  out  1  any tag-pipeline stage valid
- err  out  1  sticky: ALU valid_out disagreed with the tag pipeline

Interface: one clock; reset is synchronous and active-high. The ALU's rst_n is driven by ~rst, and the ALU's flush is tied 0. All killing is done by the tag pipeline.

Behaviour:
- Reset: on a rising edge with rst=1:
  - pointer <= 0;
  - all tag valid/kill bits <= 0;
  - err <= 0;
  - outputs req_ready=0, rsp_valid=0, busy=0, rsp_y=0 (ALU output ignored while no tag is valid).
- Reset mid-operation discards all in-flight ops; no rsp_valid for them, ever.
- Eligible set:
  - elig[i] = req_valid[i] & ~cancel[i] & ~flush & ~rst.
  - Grant is combinational: the first eligible index at or after pointer, wrapping modulo NUM_REQ. req_ready = that one-hot grant, or 0 if elig is empty.
- Accept: a handshake at edge T occurs when req_valid[i] & req_ready[i].
  - Operands of i drive the ALU with valid_in=1.
  - Tag stage 1 <= {valid=1, id=i, kill=0}.
  - pointer <= i+1 mod NUM_REQ. Pointer is unchanged when nothing is accepted.
- Latency:
  - A transaction accepted at edge T has rsp_valid[id]=1 for exactly the cycle following edge T+LATENCY-1, i.e. sampled high at edge T+LATENCY.
  - rsp_y = ALU y in that cycle.
  - Back-to-back accepts give back-to-back responses in accept order.
- Tag pipeline: LATENCY stages, shifting every cycle in lockstep with the ALU. There is no stall.
- Kill rules:
  - flush=1 sets kill on every valid stage.
  - cancel[i]=1 sets kill on every valid stage whose id==i.
  - rsp_valid is driven from the final stage with valid & ~kill & ~(kill condition in the current cycle). A response present in the same cycle as the flush/cancel is suppressed.
- Simultaneous events:
  - flush plus any req_valid: nothing accepted.
  - cancel[i] with req_valid[i]: i is skipped and the next eligible requester is granted in the same cycle.
  - cancel of a requester with nothing in flight is a no-op.
- err check: at each cycle, err <= err | (ALU valid_out != final-stage valid), independent of kill.
- Width: results are truncated to DATA_WIDTH. Shift amount is b[4:0], per the ALU.
- Starvation-free: with all NUM_REQ continuously valid, each requester is granted exactly once per NUM_REQ cycles.

Decomposition:
- alu_defines gains:
  - ALU_LATENCY = 2;
  - a tag struct typedef {valid, kill, id[$clog2(NUM_REQ)]} parameterized via localparam in the block.
- alu_op_t is reused unchanged.
- Sub-module rr_arbiter (req vector plus pointer in, one-hot grant out, combinational) is reused later for other shared units.
- alu_pipelined is instantiated unmodified.

Test Plan:
- Single requester: req 1 sends ADD(16,5) at edge T -> rsp_valid=0010 sampled at T+2, rsp_y=21; busy=1 for 2 cycles.
- All 4 valid continuously for 8 cycles with distinct ops -> grant order 0,1,2,3,0,1,2,3. Each rsp_y matches the golden model, tagged to the correct one-hot.
- flush asserted one cycle after accepts of SUB(200,10) from req 0 and XOR(300,30) from req 2 -> neither responds; next ADD(1,1) responds 2 after its accept; err stays 0.
- cancel[2] while req 2 and req 3 are both in flight -> only req 3 responds. cancel[2] with req_valid[2]=1 in the same cycle -> req 3 is granted that cycle.
- rst=1 one cycle after accepting ADD(999,111) -> no rsp_valid thereafter, pointer 0, busy 0. First post-reset accept from req 0 precedes req 1.
- Pointer wrap: only req 3 then req 0 valid -> req 3 granted, pointer wraps to 0, req 0 granted next cycle.
